// File: rtl/pwl_act_pkg.sv
// Shared constants, function selector enum, default breakpoint tables and the
// saturation helper for the piecewise-linear activation pipeline.
package pwl_act_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_FUNC = 3;
    localparam int DEF_NUM_SEG  = 2 ** DEF_ADDR_W;
    localparam int DEF_FSEL_W   = $clog2(DEF_NUM_FUNC);

    typedef enum logic [DEF_FSEL_W-1:0] {
        FUNC_TANH,
        FUNC_SIGMOID,
        FUNC_IDENT
    } func_e;

    typedef logic signed [DEF_DATA_W-1:0] bp_t;
    typedef bp_t bp_tab_t [DEF_NUM_FUNC][DEF_NUM_SEG+1];

    // Breakpoint k sits at z = k*16 - 128; tanh/sigmoid use x = z/32, scaled by 127.
    localparam bp_tab_t BP_DEFAULT = '{
        '{-8'sd127, -8'sd127, -8'sd126, -8'sd125, -8'sd122, -8'sd115, -8'sd97, -8'sd59,
          8'sd0, 8'sd59, 8'sd97, 8'sd115, 8'sd122, 8'sd125, 8'sd126, 8'sd127, 8'sd127},
        '{8'sd2, 8'sd4, 8'sd6, 8'sd10, 8'sd15, 8'sd23, 8'sd34, 8'sd48,
          8'sd64, 8'sd79, 8'sd93, 8'sd104, 8'sd112, 8'sd117, 8'sd121, 8'sd123, 8'sd125},
        '{8'sh80, -8'sd112, -8'sd96, -8'sd80, -8'sd64, -8'sd48, -8'sd32, -8'sd16,
          8'sd0, 8'sd16, 8'sd32, 8'sd48, 8'sd64, 8'sd80, 8'sd96, 8'sd112, 8'sd127}
    };

    function automatic bp_t sat(input logic signed [31:0] v);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (DEF_DATA_W - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (DEF_DATA_W - 1));
        if (v > hi) begin
            return hi[DEF_DATA_W-1:0];
        end else if (v < lo) begin
            return lo[DEF_DATA_W-1:0];
        end
        return v[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/pwl_activation_pipe_lut.sv
// Dual-read breakpoint store returning P[f][idx] and P[f][idx+1].
// With PWL_LUT_WRITE_EN defined the tables are writable registers reloaded on rst.
module pwl_act_lut
    import pwl_act_pkg::*;
(
`ifdef PWL_LUT_WRITE_EN
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lut_we,
    input  logic [DEF_FSEL_W-1:0] lut_func,
    input  logic [DEF_ADDR_W:0]   lut_idx,
    input  bp_t                   lut_wdata,
`endif
    input  logic [DEF_FSEL_W-1:0] rd_func,
    input  logic [DEF_ADDR_W-1:0] rd_idx,
    output bp_t                   rd_base,
    output bp_t                   rd_next
);

    logic [DEF_ADDR_W:0] idx_lo;
    logic [DEF_ADDR_W:0] idx_hi;

    assign idx_lo = {1'b0, rd_idx};
    assign idx_hi = idx_lo + (DEF_ADDR_W + 1)'(1);

`ifdef PWL_LUT_WRITE_EN
    bp_tab_t tab_q;
    bp_tab_t tab_d;

    always_comb begin
        tab_d = tab_q;
        if (lut_we && (32'(lut_idx) <= DEF_NUM_SEG) && (32'(lut_func) < DEF_NUM_FUNC)) begin
            tab_d[lut_func][lut_idx] = lut_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tab_q <= BP_DEFAULT;
        end else begin
            tab_q <= tab_d;
        end
    end

    // Reads are from the registered table, so a same-cycle write is not yet visible.
    assign rd_base = tab_q[rd_func][idx_lo];
    assign rd_next = tab_q[rd_func][idx_hi];
`else
    assign rd_base = BP_DEFAULT[rd_func][idx_lo];
    assign rd_next = BP_DEFAULT[rd_func][idx_hi];
`endif

endmodule

// File: rtl/pwl_activation_pipe.sv
// Three-stage piecewise-linear activation (LUT fetch, slope multiply, add+saturate)
// with a global stall. Optional runtime table writes via PWL_LUT_WRITE_EN.
module pwl_activation_pipe
    import pwl_act_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_FUNC = DEF_NUM_FUNC,
    localparam int FRAC_W  = DATA_W - ADDR_W,
    localparam int FSEL_W  = $clog2(NUM_FUNC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] z_value,
    input  logic [FSEL_W-1:0]        func_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] a_value
`ifdef PWL_LUT_WRITE_EN
    ,
    input  logic                     lut_we,
    input  logic [FSEL_W-1:0]        lut_func,
    input  logic [ADDR_W:0]          lut_idx,
    input  logic signed [DATA_W-1:0] lut_wdata
`endif
);

    localparam int PROD_W = DATA_W + FRAC_W + 2;

    logic                     adv;
    logic [ADDR_W-1:0]        idx_s0;
    logic [FRAC_W-1:0]        rem_s0;
    logic [FSEL_W-1:0]        func_s0;
    logic signed [DATA_W-1:0] lut_base;
    logic signed [DATA_W-1:0] lut_next;

    logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic signed [DATA_W-1:0] base_p1_q, base_p1_d, next_p1_q, next_p1_d;
    logic [FRAC_W-1:0]        rem_p1_q, rem_p1_d;
    logic signed [DATA_W-1:0] base_p2_q, base_p2_d;
    logic signed [PROD_W-1:0] prod_p2_q, prod_p2_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [DATA_W:0]   diff_s2;
    logic signed [31:0]       sum_s3;

    assign adv       = !vld_p3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p3_q;
    assign a_value   = a_q;

    // Offset-binary segment index: the most negative z maps to segment 0.
    assign idx_s0  = {~z_value[DATA_W-1], z_value[DATA_W-2:FRAC_W]};
    assign rem_s0  = z_value[FRAC_W-1:0];
    assign func_s0 = (32'(func_sel) < NUM_FUNC) ? func_sel : FSEL_W'(FUNC_TANH);

    pwl_act_lut u_lut (
`ifdef PWL_LUT_WRITE_EN
        .clk      (clk),
        .rst      (rst),
        .lut_we   (lut_we),
        .lut_func (lut_func),
        .lut_idx  (lut_idx),
        .lut_wdata(lut_wdata),
`endif
        .rd_func  (func_s0),
        .rd_idx   (idx_s0),
        .rd_base  (lut_base),
        .rd_next  (lut_next)
    );

    always_comb begin
        diff_s2   = $signed({next_p1_q[DATA_W-1], next_p1_q}) - $signed({base_p1_q[DATA_W-1], base_p1_q});
        sum_s3    = 32'(base_p2_q) + 32'(prod_p2_q >>> FRAC_W);
        vld_p1_d  = vld_p1_q;
        base_p1_d = base_p1_q;
        next_p1_d = next_p1_q;
        rem_p1_d  = rem_p1_q;
        vld_p2_d  = vld_p2_q;
        base_p2_d = base_p2_q;
        prod_p2_d = prod_p2_q;
        vld_p3_d  = vld_p3_q;
        a_d       = a_q;
        if (adv) begin
            // stage 1: capture the two bracketing breakpoints
            vld_p1_d  = in_valid;
            base_p1_d = lut_base;
            next_p1_d = lut_next;
            rem_p1_d  = rem_s0;
            // stage 2: segment slope times in-segment offset
            vld_p2_d  = vld_p1_q;
            base_p2_d = base_p1_q;
            prod_p2_d = diff_s2 * $signed({1'b0, rem_p1_q});
            // stage 3: floor-scaled add and saturate
            vld_p3_d  = vld_p2_q;
            if (vld_p2_q) begin
                a_d = sat(sum_s3);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            a_q      <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            a_q      <= a_d;
        end
    end

    always_ff @(posedge clk) begin
        base_p1_q <= base_p1_d;
        next_p1_q <= next_p1_d;
        rem_p1_q  <= rem_p1_d;
        base_p2_q <= base_p2_d;
        prod_p2_q <= prod_p2_d;
    end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Directed bench for pwl_activation_pipe: hand-computed vectors, stream, stall and reset.
module tb_pwl_activation_pipe;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] z_value;
    logic [1:0]        func_sel;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] a_value;
`ifdef PWL_LUT_WRITE_EN
    logic              lut_we;
    logic [1:0]        lut_func;
    logic [4:0]        lut_idx;
    logic signed [7:0] lut_wdata;
`endif

    pwl_activation_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .z_value  (z_value),
        .func_sel (func_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_value  (a_value)
`ifdef PWL_LUT_WRITE_EN
        ,
        .lut_we   (lut_we),
        .lut_func (lut_func),
        .lut_idx  (lut_idx),
        .lut_wdata(lut_wdata)
`endif
    );

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc;
    bit   mon_stream = 0;
    int   first_out;
    int   last_out;
    int   n_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard pops one expectation per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq(e.tag, int'(a_value), e.exp);
            end
            if (mon_stream) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
        end
    end

    task automatic send(input string tag, input int z, input int f, input int exp);
        int budget;
        budget   = 50;
        in_valid = 1'b1;
        z_value  = z[7:0];
        func_sel = f[1:0];
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) begin
            check_eq({tag, "_accept_timeout"}, 0, 1);
        end else begin
            sb.push_back('{tag, exp});
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

`ifdef PWL_LUT_WRITE_EN
    task automatic lut_write(input int f, input int idx, input int data);
        lut_we    = 1'b1;
        lut_func  = f[1:0];
        lut_idx   = idx[4:0];
        lut_wdata = data[7:0];
        @(posedge clk);
        #1;
        lut_we = 1'b0;
    endtask
`endif

    // Stream vectors: even entries tanh, odd entries sigmoid.
    int st_z[20] = '{0, 0, 16, 32, -16, -32, 32, -128, -32, 127,
                     8, 64, -8, -64, -128, 96, 127, 16, 48, -16};
    int st_e[20] = '{0, 64, 59, 93, -59, 34, 97, 2, -97, 124,
                     29, 112, -30, 15, -127, 121, 127, 79, 115, 48};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        z_value   = '0;
        func_sel  = '0;
        out_ready = 1'b1;
`ifdef PWL_LUT_WRITE_EN
        lut_we    = 1'b0;
        lut_func  = '0;
        lut_idx   = '0;
        lut_wdata = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_a_value", int'(a_value), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // identity table
        send("id_48", 48, 2, 48);
        send("id_m128", -128, 2, -128);
        send("id_127", 127, 2, 126);
        send("id_5", 5, 2, 5);
        send("id_m3", -3, 2, -3);
        drain();

        // tanh table, odd symmetry and floor interpolation
        send("tanh_0", 0, 0, 0);
        send("tanh_p16", 16, 0, 59);
        send("tanh_m16", -16, 0, -59);
        send("tanh_p32", 32, 0, 97);
        send("tanh_m32", -32, 0, -97);
        send("tanh_p8", 8, 0, 29);
        send("tanh_m8", -8, 0, -30);
        send("fsel3_as_tanh", 16, 3, 59);
        drain();

        // back-to-back stream with alternating functions
        first_out  = -1;
        n_out      = 0;
        mon_stream = 1'b1;
        begin
            int s0;
            s0 = 0;
            for (int i = 0; i < 20; i++) begin
                send($sformatf("stream_%0d", i), st_z[i], i % 2, st_e[i]);
                if (i == 0) s0 = last_acc;
            end
            drain();
            mon_stream = 1'b0;
            check_eq("stream_latency", first_out - s0, 3);
            check_eq("stream_span", last_out - first_out, 19);
            check_eq("stream_count", n_out, 20);
        end

        // stall with three samples in flight
        out_ready = 1'b0;
        send("stall_a", 48, 2, 48);
        send("stall_b", 16, 0, 59);
        send("stall_c", 0, 1, 64);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("stall_in_ready_%0d", i), int'(in_ready), 0);
            check_eq($sformatf("stall_out_valid_%0d", i), int'(out_valid), 1);
            check_eq($sformatf("stall_a_hold_%0d", i), int'(a_value), 48);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // reset mid-stream drops in-flight samples
        send("pre_rst_0", 16, 0, 59);
        send("pre_rst_1", 32, 0, 97);
        send("pre_rst_2", 48, 0, 115);
        send("pre_rst_3", -16, 0, -59);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_a_value", int'(a_value), 0);
        check_eq("midrst_in_ready", int'(in_ready), 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        send("post_rst", -32, 1, 34);
        drain();

`ifdef PWL_LUT_WRITE_EN
        lut_write(2, 11, 100);
        send("wr_p2_11", 48, 2, 100);
        drain();
        lut_write(2, 17, 5);
        send("wr_idx17_a", 48, 2, 100);
        send("wr_idx17_b", -112, 2, -112);
        send("wr_idx17_c", 127, 2, 126);
        drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send("wr_after_rst", 48, 2, 48);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
